// File: rtl/debounce_pulse.sv
// Two-flop synchroniser plus 4-state debounce FSM for one push-button.
// Emits a clean level and single-cycle press/release strobes.
module debounce_pulse #(
  parameter int N      = 4,
  parameter int STABLE = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_in,
  output logic o_btn_level,
  output logic o_btn_pulse,
  output logic o_btn_release,
  output logic o_busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    HIGH    = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [N-1:0] LP_LAST = N'(STABLE - 1);

  logic         r_s1;
  logic         r_s2;
  state_t       r_state;
  logic [N-1:0] r_cnt;
  logic         r_pulse;
  logic         r_release;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_btn_in;
      r_s2 <= r_s1;
    end
  end

  // Strobes are registered here so they rise together with the state change.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_pulse   <= 1'b0;
      r_release <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_s2) begin
            r_state <= WAIT_HI;
            r_cnt   <= '0;
          end
        end
        WAIT_HI: begin
          if (!r_s2) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == LP_LAST) begin
            r_state <= HIGH;
            r_pulse <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!r_s2) begin
            r_state <= WAIT_LO;
            r_cnt   <= '0;
          end
        end
        WAIT_LO: begin
          if (r_s2) begin
            r_state <= HIGH;
            r_cnt   <= '0;
          end else if (r_cnt == LP_LAST) begin
            r_state   <= IDLE;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_btn_level   = (r_state == HIGH) || (r_state == WAIT_LO);
  assign o_busy        = (r_state == WAIT_HI) || (r_state == WAIT_LO);
  assign o_btn_pulse   = r_pulse;
  assign o_btn_release = r_release;

endmodule

// File: doc/debounce_pulse.md
# debounce_pulse

Synchronises and debounces one asynchronous push-button input, and produces a clean level plus single-cycle press and release strobes. It sits directly upstream of the lab counter/register stages: `btn_pulse` is the one-cycle step/enable that advances a counter once per physical press. Debouncing uses an internal stability counter compared against a parameterised threshold, sequenced by a 4-state FSM.

## Interface
- `N`, 4: width of the internal stability counter.
- `STABLE`, 8: number of consecutive synchronised samples, beyond the first, that must agree before a level change is accepted. Legal range is 2 ≤ `STABLE` ≤ 2^N.

- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset; `rst`=0 clears all state immediately.
- `btn_in`  in  1  raw asynchronous button input, active-high.
- `btn_level`  out  1  debounced button level, registered.
- `btn_pulse`  out  1  one-cycle strobe when `btn_level` goes 0→1, registered.
- `btn_release`  out  1  one-cycle strobe when `btn_level` goes 1→0, registered.
- `busy`  out  1  high while a level change is being qualified (WAIT_HI or WAIT_LO).

## Operation
- **Synchroniser:** two flops in series, `s1` ← `btn_in` and `s2` ← `s1`. Both reset to 0. The FSM sees only `s2`.
- **Counter:** `cnt` is N bits wide and resets to 0. It never wraps, because the threshold is reached before 2^N.
- **FSM states:** IDLE (reset state), WAIT_HI, HIGH, WAIT_LO.
  - **IDLE:** if `s2`=1, go to WAIT_HI with `cnt`←0. Otherwise stay.
  - **WAIT_HI:**
    - If `s2`=0, return to IDLE. This is a bounce: no pulse is issued and `cnt` is cleared.
    - Else if `cnt`==`STABLE`-1, go to HIGH.
    - Else `cnt`←`cnt`+1.
  - **HIGH:** if `s2`=0, go to WAIT_LO with `cnt`←0. Otherwise stay.
  - **WAIT_LO:**
    - If `s2`=1, return to HIGH. No release is issued.
    - Else if `cnt`==`STABLE`-1, go to IDLE.
    - Else `cnt`←`cnt`+1.
- **Outputs:** all outputs are registered or decoded from state registers.
  - `btn_level` is 1 exactly while the state is HIGH or WAIT_LO.
  - `btn_pulse` is 1 for the single cycle following a WAIT_HI→HIGH transition.
  - `btn_release` is 1 for the single cycle following a WAIT_LO→IDLE transition.
  - `btn_pulse` and `btn_release` are never high simultaneously.
  - `busy` = (state==WAIT_HI) or (state==WAIT_LO).
- **Reset values:** every output is 0. The state is IDLE, and `cnt`, `s1` and `s2` are 0.
- **Reset mid-operation:** `rst`=0 in any state forces the reset values asynchronously, with no strobe. Any qualification in progress is discarded. A new press after reset needs the full qualification time.

## Timing
- Take edge 0 as the first rising edge at which `btn_in`=1 is captured into `s1`. Then `s2`=1 after edge 1, and the FSM enters WAIT_HI at edge 2.
- `cnt` equals j after edge 2+j. HIGH is entered at edge `STABLE`+2, when `btn_level` and `btn_pulse` rise.
  - Default values: edge 10.
  - `btn_pulse` falls at edge `STABLE`+3.
- This requires `btn_in` to stay high for at least `STABLE`+3 consecutive edges (0 … `STABLE`+2). Any 0 sampled into `s2` before that restarts qualification.
- Release is symmetric. `btn_level`=0 and `btn_release`=1 follow at edge `STABLE`+2 after the first edge capturing `btn_in`=0.
- Throughput: at most one `btn_pulse` per full press/release cycle. At least 2·(`STABLE`+1) cycles separate two consecutive `btn_pulse` strobes.
- `busy` rises with the IDLE→WAIT_HI transition (edge 2). It falls at the edge that leaves WAIT_HI or WAIT_LO.

## Test plan
All scenarios use `N`=4 and `STABLE`=8.

1. **Reset:** hold `rst`=0 with `btn_in` toggling. Then `btn_level`, `btn_pulse`, `btn_release` and `busy` all stay 0.
2. **Clean press:** `btn_in` goes 0→1 before edge 0 and is held 20 cycles. Then `busy`=1 from edge 2, `btn_pulse`=1 only between edges 10 and 11, and `btn_level`=1 from edge 10.
3. **Bouncy press:** `btn_in` is high for 5 edges, low for 1 edge, then high for 15 edges. Then exactly one `btn_pulse`, 10 edges after the final rise is captured, and no earlier strobe.
4. **Short glitch:** `btn_in` is high for 3 edges, then low. Then `busy` pulses high, and `btn_level` and `btn_pulse` stay 0.
5. **Release:** from HIGH, `btn_in`→0 and is held. Then `btn_release`=1 for exactly one cycle at edge 10, and `btn_level`=0 from edge 10. A 1-edge high blip at edge 5 delays `btn_release` until 10 edges after the blip ends.
6. **Reset mid-qualification:** assert `rst`=0 at edge 6 of a press. Outputs go to 0 immediately and no `btn_pulse` occurs. After `rst`=1, with `btn_in` still high, `btn_pulse` appears exactly `STABLE`+2 edges after the first post-reset capture edge.
